// File: rtl/instr_loader.sv
// Instruction loader: accepts decoded instruction fields, encodes them as RV32I words and
// writes them sequentially into instruction memory while holding the core stalled.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  type_MD,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [20:0] imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] LastIdx = 32'(MAX_WORDS - 1);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_bad;

  // Field-to-word encoder; unknown classes become a NOP and flag an error.
  always_comb begin
    enc_word = Nop;
    enc_bad  = 1'b0;
    case (type_MD)
      3'b000:  enc_word = {imm[11:0], rs1, 3'b010, rd, OpLoad};
      3'b001:  enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpStore};
      3'b010:  enc_word = {funct7, rs2, rs1, funct3, rd, OpReg};
      3'b011:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OpBranch};
      3'b100:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
      default: begin
        enc_word = Nop;
        enc_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    last_d   = last_q;
    err_d    = err_q;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;

    case (state_q)
      StIdle: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_d = StLoad;
          addr_d  = BASE_ADDR;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // we_d is raised here so imem_we is a flop that is high only in StWrite.
          wdata_d = enc_word;
          last_d  = in_last;
          we_d    = 1'b1;
          state_d = StWrite;
          if (enc_bad) begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + 32'd4;
        count_d = count_q + 32'd1;
        if (last_q) begin
          state_d = StDone;
        end else if (count_q == LastIdx) begin
          // Session filled without a last marker: abort.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 64, maximum words accepted per load session.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port in_valid  input  1  instruction fields valid.
REQ-007 SHALL have port in_ready  output  1  loader can accept fields this cycle.
REQ-008 SHALL have port in_last  input  1  accompanying word is the final one of the session.
REQ-009 SHALL have port type_MD  input  3  instruction class: 000 lw, 001 sw, 010 R-type, 011 beq, 100 jal.
REQ-010 SHALL have ports rd, rs1, rs2  input  5 each  register indices.
REQ-011 SHALL have ports funct3  input  3 and funct7  input  7  R-type function fields.
REQ-012 SHALL have port imm  input  21  signed immediate/offset.
REQ-013 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-014 SHALL have port imem_addr  output  32  byte write address.
REQ-015 SHALL have port imem_wdata  output  32  encoded instruction word.
REQ-016 SHALL have port cpu_hold  output  1  keeps the core stalled while loading.
REQ-017 SHALL have ports done  output  1 (session end pulse) and err  output  1 (sticky error).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-019 IDLE: in_ready=0, cpu_hold=0; start=1 -> LOAD, address counter := BASE_ADDR, word count := 0, err := 0.
REQ-020 LOAD: in_ready=1, cpu_hold=1; in_valid&in_ready -> register encoded word and in_last, go WRITE.
REQ-021 WRITE: imem_we=1 for exactly one cycle with registered imem_addr/imem_wdata, in_ready=0; then address += 4, count += 1; registered last -> DONE, else LOAD.
REQ-022 Latency: word accepted in cycle N appears with imem_we=1 in cycle N+1; max throughput one word per 2 cycles.
REQ-023 DONE: done=1 for one cycle, cpu_hold=1, then IDLE.
REQ-024 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-025 lw: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
REQ-026 sw: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
REQ-027 R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-028 beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}; imm[0] ignored.
REQ-029 jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}; imm[0] ignored.
REQ-030 type_MD 101-111 SHALL write NOP 32'h00000013 and set err.
REQ-031 Full: word written when count reaches MAX_WORDS-1 without last SHALL set err and go DONE; no further writes.
REQ-032 imem_we, imem_addr, imem_wdata SHALL be registered outputs; imem_we=0 in all states but WRITE.
REQ-033 err SHALL remain set until next accepted start or reset.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, in_ready=0, cpu_hold=0, done=0, err=0, count=0.
REQ-035 reset during WRITE SHALL suppress that write with no partial-cycle glitch on imem_we after reset assertion.

Verification
REQ-036 start; lw rd=5 rs1=2 imm=8 -> imem_wdata=32'h00812283 at addr 0, imem_we one cycle.
REQ-037 Stream sw rd-unused rs2=6 rs1=2 imm=12; R funct7=0 funct3=0 rd=1 rs1=2 rs2=3; beq rs1=1 rs2=2 imm=-4; jal rd=1 imm=8 (last) -> 32'h00612623@0, 32'h003100B3@4, 32'hFE208EE3@8, 32'h008000EF@12, done pulse, cpu_hold low after.
REQ-038 MAX_WORDS=2, send 3 words, none last -> two writes at 0 and 4, err=1, done pulse, third word not accepted.
REQ-039 type_MD=111 -> 32'h00000013 written, err=1, err held until next start.
REQ-040 reset asserted in WRITE cycle -> no write, all outputs at reset values, later start restarts at BASE_ADDR.
